// File: rtl/buzz_seq.sv
// buzz_seq: beep sequencer between the key scanner and the board buzzer.
//
// The scanner delivers key codes as 1-cycle pulses. Each code from 1 to 4 is
// queued in a 4-entry FIFO. Each queued code is played as that many tone
// bursts. Every burst is followed by a silent gap. Only one event plays at a
// time.
//
// Parameters
//   BEEP_CYC  length of one tone burst in clk cycles (1..2^24-1)
//   GAP_CYC   silent gap after every burst in clk cycles (1..2^24-1)
//   HALF_CYC  tone half-period in clk cycles (1..2^24-1)
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-high
//   key_val   key event code: 0 = none, 1..4 = event, 5..7 = ignored
//   mute      1 = suppress buzz only; sequencing carries on unchanged
//   buzz      buzzer drive, active-high square wave
//   busy      high while the FIFO holds events or a burst/gap is running
//   fifo_cnt  number of queued events, 0..4
//   ovf       1-cycle pulse: an event was dropped because the FIFO was full
module buzz_seq #(
  parameter int BEEP_CYC = 5_000_000,
  parameter int GAP_CYC  = 5_000_000,
  parameter int HALF_CYC = 12_500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_val,
  input  logic       mute,
  output logic       buzz,
  output logic       busy,
  output logic [2:0] fifo_cnt,
  output logic       ovf
);

  localparam logic [23:0] BEEP_LAST = 24'(BEEP_CYC - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYC - 1);
  localparam logic [23:0] HALF_LAST = 24'(HALF_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [23:0] cyc;         // cycles spent in the current BEEP or GAP
  logic [23:0] half;        // cycles since the last tone edge
  logic        tone;
  logic [2:0]  beeps_left;

  logic [2:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  head;

  logic        key_ok;
  logic        pop;
  logic        push;
  logic        drop;

  assign key_ok = (key_val != 3'd0) && (key_val <= 3'd4);
  assign head   = mem[rd_ptr];

  // Events leave the FIFO only from IDLE, so a running burst or gap is never
  // cut short by new input.
  assign pop  = (state == IDLE) && (fifo_cnt != 3'd0);

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = key_ok && ((fifo_cnt != 3'd4) || pop);
  assign drop = key_ok && (fifo_cnt == 3'd4) && !pop;

  // FIFO storage holds data only; its validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      ovf      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      ovf <= drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc        <= 24'd0;
      half       <= 24'd0;
      tone       <= 1'b0;
      beeps_left <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            beeps_left <= head;
            cyc        <= 24'd0;
            half       <= 24'd0;
            tone       <= 1'b1;
            state      <= BEEP;
          end
        end

        BEEP: begin
          if (cyc == BEEP_LAST) begin
            tone       <= 1'b0;
            beeps_left <= beeps_left - 3'd1;
            cyc        <= 24'd0;
            state      <= GAP;
          end else begin
            cyc <= cyc + 24'd1;
            // The square wave restarts high on every burst. It then flips
            // once every HALF_CYC cycles.
            if (half == HALF_LAST) begin
              half <= 24'd0;
              tone <= ~tone;
            end else begin
              half <= half + 24'd1;
            end
          end
        end

        GAP: begin
          if (cyc == GAP_LAST) begin
            cyc <= 24'd0;
            if (beeps_left != 3'd0) begin
              half  <= 24'd0;
              tone  <= 1'b1;
              state <= BEEP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc <= cyc + 24'd1;
          end
        end

        default: begin
          tone  <= 1'b0;
          cyc   <= 24'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign buzz = tone & ~mute;
  assign busy = (state != IDLE) | (fifo_cnt != 3'd0);

endmodule

// File: tb/tb_buzz_seq.sv
// Testbench for buzz_seq, using short timing parameters.
//
// The reference model works at event level. It keeps a queue of pending codes
// and the position inside the event currently playing. The expected buzz value
// comes from that position by arithmetic on the burst, gap and half-period
// lengths.
module tb_buzz_seq;

  localparam int B = 20;
  localparam int G = 10;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_val;
  logic       mute;
  logic       buzz;
  logic       busy;
  logic [2:0] fifo_cnt;
  logic       ovf;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int q[$];
  bit playing;
  int ev_t;
  int ev_len;
  bit ovf_m;

  buzz_seq #(.BEEP_CYC(B), .GAP_CYC(G), .HALF_CYC(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_val  (key_val),
    .mute     (mute),
    .buzz     (buzz),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tone_at(input int t);
    int slot;
    slot = t % (B + G);
    return (slot < B) && (((slot / H) % 2) == 0);
  endfunction

  function automatic void model_clear();
    q.delete();
    playing = 1'b0;
    ev_t    = 0;
    ev_len  = 0;
    ovf_m   = 1'b0;
  endfunction

  function automatic void model_step(input int key);
    bit pop;
    bit ok;
    int sz;
    int code;
    sz  = q.size();
    pop = !playing && (sz != 0);
    ok  = (key >= 1) && (key <= 4);
    if (playing) begin
      ev_t++;
      if (ev_t == ev_len) playing = 1'b0;
    end
    if (pop) begin
      code    = q.pop_front();
      playing = 1'b1;
      ev_t    = 0;
      ev_len  = code * (B + G);
    end
    ovf_m = 1'b0;
    if (ok) begin
      if (sz < 4 || pop) q.push_back(key);
      else ovf_m = 1'b1;
    end
  endfunction

  task automatic compare_outputs();
    bit exp_buzz;
    bit exp_busy;
    exp_buzz = playing && tone_at(ev_t) && !mute;
    exp_busy = playing || (q.size() != 0);
    chk("buzz",     32'(buzz),     32'(exp_buzz));
    chk("busy",     32'(busy),     32'(exp_busy));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
    chk("ovf",      32'(ovf),      32'(ovf_m));
  endtask

  // One clock cycle: drive the inputs, compare the outputs away from the
  // clock edge, then advance the model across the coming edge.
  task automatic run_cycle(input int key, input bit m);
    @(negedge clk);
    key_val = 3'(key);
    mute    = m;
    #1;
    compare_outputs();
    model_step(key);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_buzz"}, 32'(buzz),     32'd0);
    chk({tag, "_busy"}, 32'(busy),     32'd0);
    chk({tag, "_cnt"},  32'(fifo_cnt), 32'd0);
    chk({tag, "_ovf"},  32'(ovf),      32'd0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    key_val = 3'd0;
    rst     = 1'b1;
    #1;
    check_reset_outputs("rst_now");
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int key;
    bit m;
    rst     = 1'b0;
    key_val = 3'd0;
    mute    = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("por");
    do_reset(2);

    // Code 3 from reset: three bursts, then idle from cycle 92.
    run_cycle(3, 1'b0);                         // cycle 0
    run_cycle(0, 1'b0);                         // cycle 1
    chk("s1_buzz_c1", 32'(buzz), 32'd0);
    run_cycle(0, 1'b0);                         // cycle 2
    chk("s1_buzz_c2", 32'(buzz), 32'd1);
    run_idle(89);                               // cycles 3..91
    chk("s1_busy_c91", 32'(busy), 32'd1);
    run_cycle(0, 1'b0);                         // cycle 92
    chk("s1_busy_c92", 32'(busy), 32'd0);
    run_idle(10);

    // Overflow: code 1, then 2,3,4,1,2 on cycles 5..9; the last push is dropped.
    do_reset(2);
    run_cycle(1, 1'b0);
    run_idle(4);
    run_cycle(2, 1'b0);
    run_cycle(3, 1'b0);
    run_cycle(4, 1'b0);
    run_cycle(1, 1'b0);
    run_cycle(2, 1'b0);                         // cycle 9
    chk("s2_cnt_c9", 32'(fifo_cnt), 32'd4);
    run_cycle(0, 1'b0);                         // cycle 10
    chk("s2_ovf_c10", 32'(ovf), 32'd1);
    run_cycle(0, 1'b0);                         // cycle 11
    chk("s2_ovf_c11", 32'(ovf), 32'd0);
    run_idle(380);
    chk("s2_busy_end", 32'(busy), 32'd0);

    // Ignored codes 5, 6 and 7.
    do_reset(2);
    run_cycle(5, 1'b0);
    run_cycle(6, 1'b0);
    run_cycle(7, 1'b0);
    run_cycle(0, 1'b0);
    chk("s3_cnt",  32'(fifo_cnt), 32'd0);
    chk("s3_busy", 32'(busy),     32'd0);
    run_idle(5);

    // Muted code 2: silent, but busy over cycles 1..61.
    do_reset(2);
    run_cycle(2, 1'b1);
    for (int i = 1; i < 70; i++) begin
      run_cycle(0, 1'b1);
      if (i == 61) chk("s4_busy_c61", 32'(busy), 32'd1);
      if (i == 62) chk("s4_busy_c62", 32'(busy), 32'd0);
    end

    // Reset in the middle of the first burst of a code 4.
    do_reset(2);
    run_cycle(4, 1'b0);
    run_idle(9);                                // cycles 1..9
    do_reset(3);                                // asserted during cycle 10
    run_idle(150);

    // Full FIFO, push on the IDLE pop cycle: accepted without overflow.
    do_reset(2);
    run_cycle(1, 1'b0);                         // cycle 0
    run_idle(2);
    for (int i = 0; i < 4; i++) run_cycle(1, 1'b0);  // cycles 3..6
    run_idle(25);                               // cycles 7..31
    run_cycle(1, 1'b0);                         // cycle 32: pop and push
    run_cycle(0, 1'b0);                         // cycle 33
    chk("s6_cnt", 32'(fifo_cnt), 32'd4);
    chk("s6_ovf", 32'(ovf),      32'd0);
    run_idle(200);

    // Randomized traffic, with occasional mute and rare resets.
    do_reset(2);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        key = ($urandom_range(0, 99) < 4) ? int'($urandom_range(1, 7)) : 0;
        if ($urandom_range(0, 199) == 0) begin
          for (int j = 0; j < 5; j++) run_cycle(int'($urandom_range(1, 4)), 1'b0);
        end
        m = ($urandom_range(0, 9) == 0);
        run_cycle(key, m);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
